// File: rtl/crc_check.sv
// crc_check
//   Receive-side CRC-32/BZIP2 checker. A payload of up to DATA_W/8 bytes is
//   captured together with the CRC carried in the packet. The CRC is then
//   recomputed one byte per clock, most significant byte first, and the
//   result is compared against the received value.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   start_i      request pulse, accepted only while not busy
//   data_raw_i   payload word; byte 0 is data_raw_i[DATA_W-1 -: 8]
//   len_bytes_i  payload length in bytes; 0 or above DATA_W/8 means full word
//   crc_rx_i     CRC received with the packet
//   busy_o       a check is in progress
//   done_o       result valid, held until the next accepted start
//   crc_ok_o     recomputed CRC equals the received CRC (valid with done_o)
//   crc_calc_o   recomputed CRC
module crc_check #(
  parameter int DATA_W = 256,
  parameter int CRC_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_raw_i,
  input  logic [5:0]        len_bytes_i,
  input  logic [CRC_W-1:0]  crc_rx_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              crc_ok_o,
  output logic [CRC_W-1:0]  crc_calc_o
);

  localparam int              NBYTES  = DATA_W / 8;
  localparam logic [5:0]      MAX_LEN = 6'(NBYTES);
  localparam logic [CRC_W-1:0] POLY   = 32'h04C11DB7;
  localparam logic [CRC_W-1:0] INIT   = 32'hFFFFFFFF;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CRC_W-1:0]    crc_rx_q, crc_rx_d;
  logic [5:0]          len_q, len_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ok_q, ok_d;
  logic [CRC_W-1:0]    calc_q, calc_d;

  logic [5:0]          len_norm;
  logic [7:0]          cur_byte;
  logic [CRC_W-1:0]    crc_next;

  // A length of zero, or one larger than the word holds, selects the whole
  // word so the checker never runs past the captured payload.
  always_comb begin
    len_norm = len_bytes_i;
    if (len_bytes_i == 6'd0 || len_bytes_i > MAX_LEN) begin
      len_norm = MAX_LEN;
    end
  end

  // The captured payload is shifted left one byte per RUN cycle, so the
  // byte to process is always the top byte of data_q. Eight serial
  // MSB-first steps of the BZIP2 polynomial advance the CRC by one byte.
  always_comb begin
    logic fb;
    cur_byte = data_q[DATA_W-1 -: 8];
    crc_next = crc_q;
    fb       = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb       = crc_next[CRC_W-1] ^ cur_byte[i];
      crc_next = {crc_next[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  // Next-state logic. Every register holds by default; IDLE and DONE both
  // accept a new request, RUN ignores start and finishes on the byte at
  // index len_q-1, where the final XOR and comparison are latched.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    crc_rx_d = crc_rx_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    busy_d   = busy_q;
    done_d   = done_q;
    ok_d     = ok_q;
    calc_d   = calc_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d  = RUN;
          data_d   = data_raw_i;
          crc_rx_d = crc_rx_i;
          len_d    = len_norm;
          cnt_d    = 6'd0;
          crc_d    = INIT;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      RUN: begin
        data_d = data_q << 8;
        cnt_d  = cnt_q + 6'd1;
        crc_d  = crc_next;
        if (cnt_q == len_q - 6'd1) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          calc_d  = ~crc_next;
          ok_d    = (~crc_next == crc_rx_q);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any check in flight and
  // returns every output to zero straight away.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      data_q   <= '0;
      crc_rx_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      crc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ok_q     <= 1'b0;
      calc_q   <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      crc_rx_q <= crc_rx_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      crc_q    <= crc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
      calc_q   <= calc_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign crc_ok_o   = ok_q;
  assign crc_calc_o = calc_q;

endmodule

// File: doc/crc_check.md
# crc_check

Receive-side CRC-32 checker for the packet parser. It takes a received payload of up to 32 bytes (256-bit word) together with the CRC-32 carried in the packet, recomputes the CRC one byte per cycle, and reports pass/fail. It sits between the packet parser and the DMA engine, so the DMA only commits payloads that passed the check. It is the receiving counterpart of the transmit-side CRC generator.

## Interface
- `DATA_W`, 256: payload word width in bits. Must be a multiple of 8.
- `CRC_W`, 32: CRC width. Fixed at 32.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request pulse. Accepted only when `busy`=0.
- `data_raw`  in  DATA_W  payload. Byte 0 is `data_raw[255:248]`, processed first.
- `len_bytes`  in  6  number of payload bytes, 1..32. Values 0 and >32 mean 32.
- `crc_rx`  in  32  CRC received in the packet.
- `busy`  out  1  high while a check is in progress.
- `done`  out  1  result valid. Held until the next accepted `start`.
- `crc_ok`  out  1  `crc_calc`==`crc_rx`. Meaningful only while `done`=1.
- `crc_calc`  out  32  recomputed CRC.

## Operation
- CRC algorithm is CRC-32/BZIP2:
  - polynomial 0x04C11DB7;
  - initial value 0xFFFFFFFF;
  - MSB-first, no reflection of input or output;
  - final XOR 0xFFFFFFFF.
- Each cycle in RUN applies 8 serial shift steps to one byte, MSB first: `fb = reg[31]^bit; reg = {reg[30:0],1'b0} ^ (fb ? POLY : 0)`.
- Registers:
  - `data_q`, `crc_rx_q` and `len_q` are captured on an accepted `start`.
  - Byte counter `cnt`, 6 bits.
  - 32-bit CRC register `reg`.
- FSM states: IDLE, RUN, DONE.
  - IDLE: `start`=1 → capture inputs, `reg`=0xFFFFFFFF, `cnt`=0, go to RUN.
  - RUN: each edge, process byte `cnt` and increment `cnt`. On the edge that processes byte `len_q-1`:
    - `crc_calc` = ~next_reg;
    - `crc_ok` = (~next_reg == `crc_rx_q`);
    - go to DONE.
  - DONE: `done`=1 and outputs are held. `start`=1 → capture inputs, clear `done`, go to RUN (same as from IDLE).
- `start` while in RUN is ignored. It is not queued, and the captured inputs do not change.
- Input ports are sampled only on the accepting edge. Changes to them during RUN have no effect.
- `busy` = (state==RUN), driven from a register.

## Timing
- Reset values: `busy`=0, `done`=0, `crc_ok`=0, `crc_calc`=0, state IDLE.
- Reset is asynchronous. Asserting `rst` during RUN aborts the check immediately: all outputs return to their reset values and no `done` is produced.
- Latency for `start` accepted at edge N:
  - `busy`=1 after edge N;
  - bytes are processed at edges N+1 … N+len;
  - `done`=1, `busy`=0 and `crc_ok`/`crc_calc` are valid after edge N+len.
  - Worst case is 32 cycles from `start` to `done`.
- Back-to-back: `start` may be asserted in the first cycle `done` is visible. It is accepted at the next edge and `done` drops after that edge.
- Throughput: one check per len+1 cycles.
- `crc_calc`/`crc_ok` hold their previous values while in RUN. They update only at completion.
- Only bytes 0..len_q-1 affect the result. Bytes beyond `len_q` are don't-care.

## Test plan
- Basic match:
  - stimulus: `data_raw[255:184]` = ASCII "123456789" (0x313233343536373839), remaining bits random, `len_bytes`=9, `crc_rx`=0xFC891918, one-cycle `start`;
  - required: `busy` for 9 cycles, then `done`=1, `crc_calc`=0xFC891918, `crc_ok`=1.
- Mismatch: same as the basic match but `crc_rx`=0xFC891919 → `done`=1 after 9 cycles, `crc_calc`=0xFC891918, `crc_ok`=0.
- Full word:
  - stimulus: `data_raw`=256'h0123456789ABCDEF00112233445566778899AABBCCDDEEFF0F1E2D3C4B5A6978, `len_bytes`=0;
  - required: `done` exactly 32 cycles after `start`, `crc_calc` equal to the bench's bit-serial CRC-32/BZIP2 model, `crc_ok`=1 when `crc_rx` is set to that value.
- Busy protection:
  - stimulus: start the basic-match check, then pulse `start` at cycle 4 with different `data_raw`/`crc_rx`;
  - required: second request ignored, result identical to the basic match, `done` still at cycle 9.
- Reset mid-run: assert `rst` asynchronously at cycle 5 of a 32-byte run → `busy`, `done`, `crc_ok` and `crc_calc` are 0 immediately. A fresh `start` after reset release gives the correct result.
- Back-to-back:
  - stimulus: while `done`=1 from the basic match, pulse `start` with the mismatch vector;
  - required: `done` falls after the accepting edge and rises 9 cycles later with `crc_ok`=0.
